// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   a_lat, mag_a, quo, rem, mag_b;
  logic [2*WIDTH-1:0] prod;

  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Signed ops work on magnitudes; signs are reapplied in FIX.
  assign a_neg_in = ~op[0] & a[WIDTH-1];
  assign b_neg_in = ~op[0] & b[WIDTH-1];
  assign mag_a_in = a_neg_in ? -a : a;
  assign mag_b_in = b_neg_in ? -b : b;

  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_b};

  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_r ? -rem : rem;
  // A zero divisor yields all-ones quotient and the original dividend as remainder.
  assign hi_res = is_div ? (dz ? a_lat : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res = is_div ? (dz ? '1 : quo_fix) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN:  if (flush) state_nx = S_IDLE;
              else if (cnt == LAST) state_nx = S_FIX;
      S_FIX:  state_nx = flush ? S_IDLE : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      a_lat       <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      quo         <= '0;
      rem         <= '0;
      prod        <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= '0;
          is_div <= op[1];
          neg_q  <= a_neg_in ^ b_neg_in;
          neg_r  <= a_neg_in;
          dz     <= (b == '0);
          a_lat  <= a;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          quo    <= mag_a_in;
          rem    <= '0;
          prod   <= {{WIDTH{1'b0}}, mag_b_in};
        end
        S_RUN: begin
          cnt <= (flush || cnt == LAST) ? '0 : cnt + CW'(1);
          if (is_div) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!div_trial[WIDTH]) begin
              rem <= div_trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= div_shift[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        S_FIX: if (!flush) begin
          hi          <= hi_res;
          lo          <= lo_res;
          div_by_zero <= is_div & dz;
        end
        default: ;
      endcase
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - directed self-checking bench for mips_muldiv
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, seen_done;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), and record latency and busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_by_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;

    run_op(MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_busy_cycles", 64'(bcnt), 64'd33);
    check("mult_done_fall", {63'd0, done}, 64'd0);
    check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(DIVU, 32'd7, 32'd2);
    check("divu_res", {hi, lo}, {32'd1, 32'd3});

    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_num", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE);
    check("div_neg_den", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    check("div_ovf_dz", {63'd0, div_by_zero}, 64'd0);

    run_op(DIV, 32'd5, 32'd0);
    check("dz_lat", 64'(lat), 64'd33);
    check("dz_res", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    check("dz_flag", {63'd0, div_by_zero}, 64'd1);
    run_op(MULTU, 32'd2, 32'd3);
    check("dz_clear_res", {hi, lo}, {32'd0, 32'd6});
    check("dz_clear_flag", {63'd0, div_by_zero}, 64'd0);

    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'd0, 32'h1234});

    op = MULT; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = MULTU;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    check("busy_ignores_start", {63'd0, busy}, 64'd1);
    check("busy_drops_mthi", {hi, lo}, {32'd0, 32'h1234});
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hilo", {hi, lo}, {32'd0, 32'h1234});

    op = DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check("async_rst_out", {busy, done, div_by_zero}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    run_op(MULTU, 32'd4, 32'd4);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_res", {hi, lo}, {32'd0, 32'd16});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
